// File: rtl/ffsr_binary_pulse_drive_if.sv
// ---------------------------------------------------------------------------
// ffsr_binary_pulse_drive_if
//   Request and pulse-drive bundle for ffsr_binary_pulse_drive.
//
//   Handshake: a request transfers on a rising clk edge where in_valid=1 and
//   in_ready=1. The producer holds target stable while in_valid is high. The
//   block drops in_ready while a pulse train runs or while clr is high; a
//   request presented while in_ready=0 is ignored, not queued.
//
//   Signals:
//     in_valid / in_ready / target : request handshake (target is unsigned)
//     clr                          : synchronous clear of mirror, aborts train
//     inc / dec                    : single-cycle pulses to downstream counter
//     busy                         : pulse train in progress
//     done                         : one-cycle completion strobe
//     mirror                       : count the downstream counter will hold
// ---------------------------------------------------------------------------
interface ffsr_binary_pulse_drive_if #(
  parameter int WIDTH = 3
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] target;
  logic             clr;
  logic             inc;
  logic             dec;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] mirror;

  modport master (
    output in_valid, target, clr,
    input  in_ready, inc, dec, busy, done, mirror
  );

  modport slave (
    input  in_valid, target, clr,
    output in_ready, inc, dec, busy, done, mirror
  );
endinterface

// File: rtl/ffsr_binary_pulse_drive.sv
// ---------------------------------------------------------------------------
// ffsr_binary_pulse_drive
//   Converts a binary target count into a train of single-cycle inc or dec
//   pulses for a downstream up/down pulse counter. An internal mirror tracks
//   the downstream count so each request only sends the difference.
//
//   Parameters:
//     WIDTH : width of target, mirror and the downstream counter
//     GAP   : low cycles between consecutive pulses (0 = back-to-back)
//
//   Ports:
//     clk       : clock, all state on rising edge
//     rst       : asynchronous active-low reset
//     bus       : request / pulse bundle (slave side)
//     state_dbg : current FSM state (IDLE=0, PULSE=1, GAP=2)
// ---------------------------------------------------------------------------
module ffsr_binary_pulse_drive #(
  parameter int WIDTH = 3,
  parameter int GAP   = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  ffsr_binary_pulse_drive_if.slave   bus,
  output logic [1:0]                 state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PULSE = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  localparam int GW     = (GAP > 1) ? $clog2(GAP) : 1;
  localparam int GAP_M1 = (GAP > 0) ? GAP - 1 : 0;

  localparam logic [WIDTH-1:0] ONE_W    = WIDTH'(1);
  localparam logic [GW-1:0]    ONE_G    = GW'(1);
  localparam logic [GW-1:0]    GAP_LOAD = GW'(GAP_M1);

  state_t           state_q, state_d;
  logic             inc_q, inc_d;
  logic             dec_q, dec_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] mirror_q, mirror_d;
  logic [WIDTH-1:0] rem_q, rem_d;      // pulses still to send after the current one
  logic             dir_q, dir_d;      // 1 = counting down (dec pulses)
  logic [GW-1:0]    gap_q, gap_d;

  logic             in_ready_c;
  logic             accept;
  logic             tgt_below;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] step_mirror;

  assign in_ready_c  = (state_q == S_IDLE) && !bus.clr;
  assign accept      = bus.in_valid && in_ready_c;
  assign tgt_below   = bus.target < mirror_q;
  assign diff        = tgt_below ? (mirror_q - bus.target) : (bus.target - mirror_q);
  // Mirror moves on the same edge that raises each pulse, using the latched direction.
  assign step_mirror = dir_q ? (mirror_q - ONE_W) : (mirror_q + ONE_W);

  always_comb begin
    state_d  = state_q;
    inc_d    = 1'b0;
    dec_d    = 1'b0;
    done_d   = 1'b0;
    mirror_d = mirror_q;
    rem_d    = rem_q;
    dir_d    = dir_q;
    gap_d    = gap_q;

    if (bus.clr) begin
      state_d  = S_IDLE;
      mirror_d = '0;
      rem_d    = '0;
      gap_d    = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            if (diff == '0) begin
              done_d = 1'b1;
            end else begin
              dir_d    = tgt_below;
              inc_d    = !tgt_below;
              dec_d    = tgt_below;
              mirror_d = tgt_below ? (mirror_q - ONE_W) : (mirror_q + ONE_W);
              rem_d    = diff - ONE_W;
              state_d  = S_PULSE;
            end
          end
        end

        S_PULSE: begin
          if (rem_q == '0) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else if (GAP == 0) begin
            inc_d    = !dir_q;
            dec_d    = dir_q;
            mirror_d = step_mirror;
            rem_d    = rem_q - ONE_W;
          end else begin
            gap_d   = GAP_LOAD;
            state_d = S_GAP;
          end
        end

        S_GAP: begin
          if (gap_q == '0) begin
            inc_d    = !dir_q;
            dec_d    = dir_q;
            mirror_d = step_mirror;
            rem_d    = rem_q - ONE_W;
            state_d  = S_PULSE;
          end else begin
            gap_d = gap_q - ONE_G;
          end
        end

        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      inc_q    <= 1'b0;
      dec_q    <= 1'b0;
      done_q   <= 1'b0;
      mirror_q <= '0;
      rem_q    <= '0;
      dir_q    <= 1'b0;
      gap_q    <= '0;
    end else begin
      state_q  <= state_d;
      inc_q    <= inc_d;
      dec_q    <= dec_d;
      done_q   <= done_d;
      mirror_q <= mirror_d;
      rem_q    <= rem_d;
      dir_q    <= dir_d;
      gap_q    <= gap_d;
    end
  end

  assign bus.in_ready = in_ready_c;
  assign bus.inc      = inc_q;
  assign bus.dec      = dec_q;
  assign bus.done     = done_q;
  assign bus.busy     = (state_q != S_IDLE);
  assign bus.mirror   = mirror_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_ffsr_binary_pulse_drive.sv
// ---------------------------------------------------------------------------
// tb_ffsr_binary_pulse_drive
//   Two instances: dut_a with GAP=1, dut_b with GAP=0, both WIDTH=3.
//   Each expected transaction records the done cycle (relative to the
//   accepting edge), the cycles where inc/dec were high (bit n = cycle n),
//   and the final mirror value.
// ---------------------------------------------------------------------------
module tb_ffsr_binary_pulse_drive;
  localparam int W = 3;

  typedef struct packed {
    logic [7:0]   done_cyc;
    logic [31:0]  inc_pat;
    logic [31:0]  dec_pat;
    logic [W-1:0] mirror;
  } exp_t;

  // clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ffsr_binary_pulse_drive_if #(.WIDTH(W)) a_if ();
  ffsr_binary_pulse_drive_if #(.WIDTH(W)) b_if ();
  logic [1:0] a_state;
  logic [1:0] b_state;

  ffsr_binary_pulse_drive #(.WIDTH(W), .GAP(1)) dut_a (
    .clk(clk), .rst(rst_n), .bus(a_if.slave), .state_dbg(a_state)
  );
  ffsr_binary_pulse_drive #(.WIDTH(W), .GAP(0)) dut_b (
    .clk(clk), .rst(rst_n), .bus(b_if.slave), .state_dbg(b_state)
  );

  // downstream 3-bit up/down pulse counter fed by dut_a
  logic [W-1:0] ds_cnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)        ds_cnt <= '0;
    else if (a_if.inc) ds_cnt <= ds_cnt + 3'd1;
    else if (a_if.dec) ds_cnt <= ds_cnt - 3'd1;
  end

  // scoreboard
  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t exp_a[$];
  exp_t exp_b[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  int          trk [2];
  int          cyc [2];
  logic [31:0] ipat [2];
  logic [31:0] dpat [2];

  task automatic mon_step(input int id, input logic inc, input logic dec, input logic done,
                          input logic vld, input logic rdy, input logic clr,
                          input logic [W-1:0] mir);
    exp_t e;
    bit   have;
    check(id == 0 ? "a_inc_dec_excl" : "b_inc_dec_excl", inc & dec, 0);
    if (trk[id] != 0) begin
      cyc[id]++;
      if (cyc[id] < 32) begin
        if (inc) ipat[id][cyc[id]] = 1'b1;
        if (dec) dpat[id][cyc[id]] = 1'b1;
      end
      if (done) begin
        have = (id == 0) ? (exp_a.size() != 0) : (exp_b.size() != 0);
        if (!have) begin
          n_checks++;
          $display("FAIL done_unexpected dut%0d: got done=1 required no done at %0t", id, $time);
        end else begin
          if (id == 0) e = exp_a.pop_front();
          else         e = exp_b.pop_front();
          check("done_cycle", cyc[id], e.done_cyc);
          check("inc_pattern", ipat[id], e.inc_pat);
          check("dec_pattern", dpat[id], e.dec_pat);
          check("final_mirror", mir, e.mirror);
        end
        trk[id] = 0;
      end
    end else if (done) begin
      n_checks++;
      $display("FAIL done_unexpected dut%0d: got done=1 required no done at %0t", id, $time);
    end
    if (clr) trk[id] = 0;
    if (vld && rdy && !clr) begin
      trk[id]  = 1;
      cyc[id]  = 0;
      ipat[id] = '0;
      dpat[id] = '0;
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) trk[0] = 0;
    else mon_step(0, a_if.inc, a_if.dec, a_if.done, a_if.in_valid, a_if.in_ready, a_if.clr, a_if.mirror);
  end

  always @(negedge clk) begin
    if (!rst_n) trk[1] = 0;
    else mon_step(1, b_if.inc, b_if.dec, b_if.done, b_if.in_valid, b_if.in_ready, b_if.clr, b_if.mirror);
  end

  // driver tasks
  task automatic req_a(input logic [W-1:0] t);
    @(posedge clk); #1;
    a_if.in_valid = 1'b1;
    a_if.target   = t;
    @(posedge clk); #1;
    a_if.in_valid = 1'b0;
  endtask

  task automatic wait_done_a();
    bit seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (a_if.done) seen = 1;
    end
    check("a_done_timeout", seen, 1);
  endtask

  task automatic clr_a();
    @(posedge clk); #1;
    a_if.clr = 1'b1;
    @(negedge clk);
    check("clr_in_ready", a_if.in_ready, 0);
    @(posedge clk); #1;
    a_if.clr = 1'b0;
    @(negedge clk);
    check("clr_mirror", a_if.mirror, 0);
    check("clr_busy", a_if.busy, 0);
  endtask

  initial begin
    trk[0] = 0; trk[1] = 0;
    a_if.in_valid = 1'b0; a_if.target = '0; a_if.clr = 1'b0;
    b_if.in_valid = 1'b0; b_if.target = '0; b_if.clr = 1'b0;

    // reset
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("rst_a_inc", a_if.inc, 0);
    check("rst_a_dec", a_if.dec, 0);
    check("rst_a_done", a_if.done, 0);
    check("rst_a_busy", a_if.busy, 0);
    check("rst_a_mirror", a_if.mirror, 0);
    check("rst_a_in_ready", a_if.in_ready, 1);
    check("rst_b_busy", b_if.busy, 0);
    check("rst_b_mirror", b_if.mirror, 0);
    check("rst_b_in_ready", b_if.in_ready, 1);

    // GAP=1: 0 -> 5, inc in cycles 1,3,5,7,9, done in 10
    exp_a.push_back('{done_cyc: 8'd10, inc_pat: 32'h0000_02AA, dec_pat: 32'h0, mirror: 3'd5});
    req_a(3'd5);
    wait_done_a();
    check("a_mirror_5", a_if.mirror, 5);
    check("downstream_5", ds_cnt, 5);

    // GAP=1: 5 -> 2, dec in cycles 1,3,5, done in 6
    exp_a.push_back('{done_cyc: 8'd6, inc_pat: 32'h0, dec_pat: 32'h0000_002A, mirror: 3'd2});
    req_a(3'd2);
    wait_done_a();

    // 2 -> 2: no pulses, done in cycle 1
    exp_a.push_back('{done_cyc: 8'd1, inc_pat: 32'h0, dec_pat: 32'h0, mirror: 3'd2});
    req_a(3'd2);
    wait_done_a();
    check("downstream_2", ds_cnt, 2);

    // GAP=0: 0 -> 7, inc cycles 1..7, done in 8; in_valid at cycle 3 ignored
    exp_b.push_back('{done_cyc: 8'd8, inc_pat: 32'h0000_00FE, dec_pat: 32'h0, mirror: 3'd7});
    @(posedge clk); #1;
    b_if.in_valid = 1'b1;
    b_if.target   = 3'd7;
    @(posedge clk); #1;
    b_if.in_valid = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      check("b_in_ready", b_if.in_ready, (c == 8) ? 1 : 0);
      check("b_busy", b_if.busy, (c < 8) ? 1 : 0);
      if (c == 3) begin
        #2;
        b_if.in_valid = 1'b1;
        b_if.target   = 3'd0;
      end
      if (c == 4) begin
        #2;
        b_if.in_valid = 1'b0;
      end
    end
    @(negedge clk);
    check("b_mirror_7", b_if.mirror, 7);

    // abort with clr: 0 -> 6, clr during cycle 4 with a competing request
    clr_a();
    req_a(3'd6);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c == 1) begin
        check("abort_c1_inc", a_if.inc, 1);
        check("abort_c1_mirror", a_if.mirror, 1);
      end
      if (c == 4) begin
        check("abort_c4_inc", a_if.inc, 0);
        #2;
        a_if.clr      = 1'b1;
        a_if.in_valid = 1'b1;
        a_if.target   = 3'd3;
      end
      if (c == 5) begin
        check("abort_c5_inc", a_if.inc, 0);
        check("abort_c5_mirror", a_if.mirror, 0);
        check("abort_c5_busy", a_if.busy, 0);
        check("abort_c5_done", a_if.done, 0);
        check("abort_c5_in_ready", a_if.in_ready, 0);
        #2;
        a_if.clr      = 1'b0;
        a_if.in_valid = 1'b0;
      end
    end
    @(negedge clk);
    check("abort_c6_busy", a_if.busy, 0);
    check("abort_c6_done", a_if.done, 0);

    exp_a.push_back('{done_cyc: 8'd2, inc_pat: 32'h0000_0002, dec_pat: 32'h0, mirror: 3'd1});
    req_a(3'd1);
    wait_done_a();

    // abort with async reset: 0 -> 6, rst low mid cycle 5
    clr_a();
    req_a(3'd6);
    for (int c = 1; c <= 5; c++) @(negedge clk);
    check("rst_abort_inc_before", a_if.inc, 1);
    check("rst_abort_mirror_before", a_if.mirror, 3);
    #1 rst_n = 1'b0;
    #1;
    check("rst_abort_inc", a_if.inc, 0);
    check("rst_abort_busy", a_if.busy, 0);
    check("rst_abort_mirror", a_if.mirror, 0);
    @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;

    exp_a.push_back('{done_cyc: 8'd2, inc_pat: 32'h0000_0002, dec_pat: 32'h0, mirror: 3'd1});
    req_a(3'd1);
    wait_done_a();
    check("downstream_1", ds_cnt, 1);

    repeat (3) @(negedge clk);
    check("exp_a_drained", exp_a.size(), 0);
    check("exp_b_drained", exp_b.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish required finish by 200000");
    $fatal(1, "timeout");
  end

endmodule
